// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
//   Registered N-channel, W-bit multiplexer with a valid/ready output stream.
//   In manual mode the s port picks the channel. In scan mode an internal
//   pointer walks all channels, holding each for DWELL captured samples.
//
// Ports
//   clk      in   clock, all state on the rising edge
//   rst      in   asynchronous active-high reset
//   i        in   packed channel data, channel k = i[k*WIDTH +: WIDTH]
//   s        in   manual channel select
//   mode     in   0 = manual, 1 = scan (sampled only when a capture happens)
//   en       in   capture enable
//   o        out  registered selected data
//   o_ch     out  channel index o was captured from
//   o_valid  out  o/o_ch/o_err hold a sample
//   o_ready  in   downstream accepts when o_valid && o_ready
//   o_err    out  captured select was >= CHANNELS (o forced to 0)
// ---------------------------------------------------------------------------
module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]          s,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          o,
    output logic [SEL_W-1:0]          o_ch,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic                      o_err
);

    localparam logic [SEL_W:0]   CH_COUNT   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         dcnt_q, dcnt_d;
    // Mode seen at the previous capture; a 0->1 change restarts the scan.
    logic               mode_prev_q, mode_prev_d;

    // Unpack the channel bus into an array for indexed selection.
    logic [WIDTH-1:0]   ch_data [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign ch_data[gi] = i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic               capture;
    logic               accept;
    logic               restart;
    logic [SEL_W-1:0]   scan_ptr;
    logic [7:0]         scan_dcnt;
    logic [SEL_W-1:0]   sel_ch;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_err;

    // Source selection. A select with no matching channel leaves data at 0,
    // which is exactly the out-of-range behaviour wanted on o.
    always_comb begin
        restart   = mode && !mode_prev_q;
        scan_ptr  = restart ? '0 : ptr_q;
        scan_dcnt = restart ? '0 : dcnt_q;
        sel_ch    = mode ? scan_ptr : s;
        sel_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_ch == SEL_W'(k)) begin
                sel_data = ch_data[k];
            end
        end
        sel_err = ({1'b0, sel_ch} >= CH_COUNT);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        o_d         = o_q;
        ch_d        = ch_q;
        err_d       = err_q;
        ptr_d       = ptr_q;
        dcnt_d      = dcnt_q;
        mode_prev_d = mode_prev_q;

        accept  = (state_q == HOLD) && o_ready;
        // A stalled sample blocks new captures; an accept frees the register
        // in the same cycle so back-to-back capture has no bubble.
        capture = en && ((state_q == IDLE) || o_ready);

        if (capture) begin
            state_d     = HOLD;
            o_d         = sel_data;
            ch_d        = sel_ch;
            err_d       = sel_err;
            mode_prev_d = mode;
            if (mode) begin
                if (scan_dcnt >= DWELL_LAST) begin
                    dcnt_d = '0;
                    ptr_d  = (scan_ptr >= PTR_LAST) ? '0 : scan_ptr + SEL_W'(1);
                end else begin
                    dcnt_d = scan_dcnt + 8'd1;
                    ptr_d  = scan_ptr;
                end
            end
        end else if (accept) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            o_q         <= '0;
            ch_q        <= '0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            dcnt_q      <= '0;
            mode_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_q         <= o_d;
            ch_q        <= ch_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
            dcnt_q      <= dcnt_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign o       = o_q;
    assign o_ch    = ch_q;
    assign o_err   = err_q;
    assign o_valid = (state_q == HOLD);

endmodule
